// File: rtl/pcie_ss_axis_tlp_checker.sv
// In-band-header TLP stream checker: header length vs byte count, tkeep shape.
// Optional random backpressure with PCIE_SS_TLP_CHECKER_BACKPRESSURE_EN.
module pcie_ss_axis_tlp_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_PKTS   = 64,
  parameter int HDR_BYTES  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_tvalid,
  output logic                    rx_tready,
  input  logic [DATA_WIDTH-1:0]   rx_tdata,
  input  logic [DATA_WIDTH/8-1:0] rx_tkeep,
  input  logic                    rx_tlast,
  output logic [15:0]             pkt_cnt,
  output logic                    err_len,
  output logic                    err_keep,
  output logic                    error,
  output logic                    done
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(KW + 1);

  typedef enum logic {
    SOP,
    BODY
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rdy_q;
  logic [12:0] acc_q;
  logic [12:0] exp_q;

  logic          beat;
  logic          eop;
  logic [PW-1:0] pop;
  logic          has_data;
  logic [9:0]    len_dw;
  logic [12:0]   len_bytes;
  logic [12:0]   hdr_exp;
  logic [12:0]   exp_cur;
  logic [12:0]   acc_base;
  logic [13:0]   acc_sum;
  logic [12:0]   acc_nx;
  logic          keep_ones;
  logic          keep_contig;
  logic          keep_bad;
  logic [15:0]   cnt_nx;
  logic          unused;

  assign unused = ^{rx_tdata[DATA_WIDTH-1:31], rx_tdata[29:10]};

`ifdef PCIE_SS_TLP_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign rx_tready = rdy_q & lfsr_q[0] & ~rst;
`else
  assign rx_tready = rdy_q & ~rst;
`endif

  assign beat = rx_tvalid & rx_tready;
  assign eop  = beat & rx_tlast;

  always_comb begin
    pop = '0;
    for (int i = 0; i < KW; i++) begin
      pop = pop + PW'(rx_tkeep[i]);
    end
  end

  // A zero length field encodes the 1024-DW maximum payload.
  assign has_data  = rx_tdata[30];
  assign len_dw    = rx_tdata[9:0];
  assign len_bytes = (len_dw == 10'd0) ? 13'd4096 : {1'b0, len_dw, 2'b00};
  assign hdr_exp   = 13'(HDR_BYTES) + (has_data ? len_bytes : 13'd0);

  assign exp_cur  = (state == SOP) ? hdr_exp : exp_q;
  assign acc_base = (state == SOP) ? 13'd0 : acc_q;
  assign acc_sum  = {1'b0, acc_base} + 14'(pop);
  assign acc_nx   = acc_sum[13] ? 13'h1FFF : acc_sum[12:0];

  // Last beat must be 2^k-1 with k>=1; other beats all-ones.
  assign keep_ones   = &rx_tkeep;
  assign keep_contig = (|rx_tkeep) &&
                       ((rx_tkeep & (rx_tkeep + KW'(1))) == '0);
  assign keep_bad    = rx_tlast ? ~keep_contig : ~keep_ones;

  assign cnt_nx = (pkt_cnt == 16'hFFFF) ? pkt_cnt : pkt_cnt + 16'd1;

  always_comb begin
    state_nx = state;
    unique case (state)
      SOP:  if (beat && !rx_tlast) state_nx = BODY;
      BODY: if (eop) state_nx = SOP;
      default: state_nx = SOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SOP;
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      exp_q    <= '0;
      pkt_cnt  <= '0;
      err_len  <= 1'b0;
      err_keep <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;
      if (beat) begin
        acc_q <= acc_nx;
        if (state == SOP) exp_q <= hdr_exp;
        if (keep_bad) err_keep <= 1'b1;
      end
      if (eop) begin
        if (acc_nx != exp_cur) err_len <= 1'b1;
        pkt_cnt <= cnt_nx;
        if (32'(cnt_nx) >= 32'(NUM_PKTS)) done <= 1'b1;
      end
    end
  end

  assign error = err_len | err_keep;

endmodule

// File: tb/tb_pcie_ss_axis_tlp_checker.sv
// Directed bench for pcie_ss_axis_tlp_checker: vector table plus
// multi-cycle sequences for done timing and mid-packet reset.
module tb_pcie_ss_axis_tlp_checker;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int NP = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HALF = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_tvalid = 1'b0;
  logic          rx_tready;
  logic [DW-1:0] rx_tdata = '0;
  logic [KW-1:0] rx_tkeep = '0;
  logic          rx_tlast = 1'b0;
  logic [15:0]   pkt_cnt;
  logic          err_len;
  logic          err_keep;
  logic          error;
  logic          done;

  int checks = 0;
  int errors = 0;
  bit saw_low = 1'b0;

  pcie_ss_axis_tlp_checker #(
    .DATA_WIDTH(DW),
    .NUM_PKTS  (NP),
    .HDR_BYTES (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready),
    .rx_tdata (rx_tdata),
    .rx_tkeep (rx_tkeep),
    .rx_tlast (rx_tlast),
    .pkt_cnt  (pkt_cnt),
    .err_len  (err_len),
    .err_keep (err_keep),
    .error    (error),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rx_tvalid && !rx_tready) saw_low = 1'b1;
  end

  typedef struct {
    string       name;
    logic [31:0] dw0;
    int          n;
    logic [63:0] k_mid;
    logic [63:0] k_last;
    bit          e_len;
    bit          e_keep;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l);
    int t = 0;
    @(negedge clk);
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    rx_tkeep  = k;
    rx_tlast  = l;
    while (!rx_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!rx_tready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got tready 0 expected 1");
    end
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] dw0, input int n,
                          input logic [63:0] k_mid, input logic [63:0] k_last);
    logic [DW-1:0] d;
    for (int b = 0; b < n; b++) begin
      d = {16{$urandom()}};
      if (b == 0) d[31:0] = dw0;
      send_beat(d, (b == n - 1) ? k_last : k_mid, b == n - 1);
    end
  endtask

  task automatic do_reset(input bit check_outs);
    @(negedge clk);
    rst = 1'b1;
    rx_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (check_outs) begin
      chk("rst_tready", int'(rx_tready), 0);
      chk("rst_pkt_cnt", int'(pkt_cnt), 0);
      chk("rst_err_len", int'(err_len), 0);
      chk("rst_err_keep", int'(err_keep), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_done", int'(done), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"mwr16_good", 32'h4000_0010, 2, ONES, HALF, 0, 0};
    vecs[1] = '{"mrd_nodata", 32'h0000_0001, 1, ONES, HALF, 0, 0};
    vecs[2] = '{"mwr16_short", 32'h4000_0010, 2, ONES,
                64'h0000_FFFF_FFFF_FFFF, 1, 0};
    vecs[3] = '{"mid_keep", 32'h4000_0010, 2, 64'h7FFF_FFFF_FFFF_FFFF,
                64'h0000_0001_FFFF_FFFF, 0, 1};
    vecs[4] = '{"last_hole", 32'h4000_0010, 2, ONES,
                64'h0000_0000_FFFF_00FF, 1, 1};
    vecs[5] = '{"zero_keep", 32'h0000_0001, 1, ONES, 64'h0, 1, 1};
    vecs[6] = '{"mwr_len0_1024", 32'h4000_0000, 65, ONES, HALF, 0, 0};
    vecs[7] = '{"mrd_len0", 32'h0000_0000, 1, ONES, HALF, 0, 0};
    vecs[8] = '{"mwr32_3beat", 32'h4000_0020, 3, ONES, HALF, 0, 0};

    do_reset(1'b1);

    foreach (vecs[i]) begin
      do_reset(1'b0);
      send_pkt(vecs[i].dw0, vecs[i].n, vecs[i].k_mid, vecs[i].k_last);
      @(negedge clk);
      chk({vecs[i].name, "_pkt_cnt"}, int'(pkt_cnt), 1);
      chk({vecs[i].name, "_err_len"}, int'(err_len), int'(vecs[i].e_len));
      chk({vecs[i].name, "_err_keep"}, int'(err_keep), int'(vecs[i].e_keep));
      chk({vecs[i].name, "_error"}, int'(error),
          int'(vecs[i].e_len | vecs[i].e_keep));
      chk({vecs[i].name, "_done"}, int'(done), 0);
    end

    // done rises with the 4th count and holds; traffic after done is checked
    do_reset(1'b0);
    for (int p = 0; p < NP; p++) begin
      send_pkt(32'h4000_0010, 2, ONES, HALF);
      @(negedge clk);
      chk("seq_pkt_cnt", int'(pkt_cnt), p + 1);
      chk("seq_done", int'(done), (p == NP - 1) ? 1 : 0);
    end
    repeat (3) @(negedge clk);
    chk("done_hold", int'(done), 1);
    send_pkt(32'h0000_0001, 1, ONES, HALF);
    @(negedge clk);
    chk("post_done_cnt", int'(pkt_cnt), NP + 1);
    chk("post_done_err", int'(error), 0);
    send_pkt(32'h4000_0010, 2, ONES, 64'h0000_0000_0000_FFFF);
    @(negedge clk);
    chk("post_done_len", int'(err_len), 1);
    chk("post_done_still", int'(done), 1);

    // orphaned partial packet discarded by reset
    do_reset(1'b0);
    send_beat({16{32'h4000_0010}}, ONES, 1'b0);
    do_reset(1'b1);
    for (int p = 0; p < NP; p++) send_pkt(32'h4000_0010, 2, ONES, HALF);
    @(negedge clk);
    chk("orphan_err", int'(error), 0);
    chk("orphan_cnt", int'(pkt_cnt), NP);
    chk("orphan_done", int'(done), 1);

    // long mixed stream; under backpressure tready must drop
    do_reset(1'b0);
    saw_low = 1'b0;
    for (int p = 0; p < 64; p++) begin
      if (p[0]) send_pkt(32'h0000_0001, 1, ONES, HALF);
      else      send_pkt(32'h4000_0010, 2, ONES, HALF);
    end
    @(negedge clk);
    chk("stream_err", int'(error), 0);
    chk("stream_cnt", int'(pkt_cnt), 64);
    chk("stream_done", int'(done), 1);
`ifdef PCIE_SS_TLP_CHECKER_BACKPRESSURE_EN
    chk("tready_low_seen", int'(saw_low), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
